sync_fifo_ram: RTL and testbench



---
 rtl/sync_fifo_ram.sv | 102 ++++++++++
 tb/tb_sync_fifo_ram.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO over an inferred simple-dual-port RAM with
// occupancy flags, overflow/underflow pulses, flush and 1- or 2-cycle read latency.
module sync_fifo_ram #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "TRUE",
  parameter int    PROG_FULL  = 2**ADDR_WIDTH-2,
  parameter int    PROG_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PF_W    = (ADDR_WIDTH+1)'(PROG_FULL);
  localparam logic [ADDR_WIDTH:0] PE_W    = (ADDR_WIDTH+1)'(PROG_EMPTY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic                  rv1_q;

  // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
  always_comb begin
    wr_ok   = we & ~full_q & ~flush;
    rd_ok   = re & ~empty_q & ~flush;
    wptr_d  = flush ? '0 : wptr_q + {{ADDR_WIDTH{1'b0}}, wr_ok};
    rptr_d  = flush ? '0 : rptr_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk)
    if (wr_ok) mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rd1_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= count_d == DEPTH_W;
      empty_q  <= count_d == '0;
      afull_q  <= count_d >= PF_W;
      aempty_q <= count_d <= PE_W;
      ovf_q    <= we & full_q & ~flush;
      udf_q    <= re & empty_q & ~flush;
      rv1_q    <= rd_ok;
      if (rd_ok) rd1_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
    end

  if (OUTPUT_REG == "TRUE") begin : g_oreg
    logic [DATA_WIDTH-1:0] rd2_q;
    logic                  rv2_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rv2_q <= rv1_q & ~flush;
        if (rv1_q & ~flush) rd2_q <= rd1_q;
      end
    assign rdata  = rd2_q;
    assign rvalid = rv2_q;
  end else begin : g_noreg
    assign rdata  = rd1_q;
    assign rvalid = rv1_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_ram.sv
// tb_sync_fifo_ram: scoreboard bench running latency-1 and latency-2 FIFOs
// side by side on identical stimulus.
module tb_sync_fifo_ram;
  logic       clk = 1'b0, rst_n = 1'b1, flush = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic       ovf0, ovf1, udf0, udf1;
  logic [4:0] count0, count1;

  typedef struct {logic [7:0] d; int c;} exp_t;
  exp_t       q0[$], q1[$];
  logic [7:0] mq[$];
  logic       exp_ovf = 1'b0, exp_udf = 1'b0;
  int         cyc = 0, errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("FALSE"), .PROG_FULL(14), .PROG_EMPTY(2)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("TRUE"), .PROG_FULL(14), .PROG_EMPTY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_dut(input string s, input logic [4:0] cnt, input logic fu, em, af, ae, ov, un);
    int n;
    n = mq.size();
    chk({s, "count"}, 32'(cnt), 32'(n));
    chk({s, "full"}, 32'(fu), 32'(n == 16));
    chk({s, "empty"}, 32'(em), 32'(n == 0));
    chk({s, "almost_full"}, 32'(af), 32'(n >= 14));
    chk({s, "almost_empty"}, 32'(ae), 32'(n <= 2));
    chk({s, "overflow"}, 32'(ov), 32'(exp_ovf));
    chk({s, "underflow"}, 32'(un), 32'(exp_udf));
  endtask

  task automatic chk_state();
    chk_dut("l1_", count0, full0, empty0, af0, ae0, ovf0, udf0);
    chk_dut("l2_", count1, full1, empty1, af1, ae1, ovf1, udf1);
  endtask

  task automatic chk_reset();
    chk_state();
    chk("l1_rst_rdata", 32'(rdata0), 32'(0));
    chk("l2_rst_rdata", 32'(rdata1), 32'(0));
    chk("l1_rst_rvalid", 32'(rvalid0), 32'(0));
    chk("l2_rst_rvalid", 32'(rvalid1), 32'(0));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cyc_op(input logic w, input logic r, input logic [7:0] d, input logic f);
    logic wr_ok, rd_ok;
    we = w; re = r; wdata = d; flush = f;
    wr_ok   = w && !f && mq.size() < 16;
    rd_ok   = r && !f && mq.size() > 0;
    exp_ovf = w && !f && mq.size() == 16;
    exp_udf = r && !f && mq.size() == 0;
    if (rd_ok) begin
      q0.push_back('{mq[0], cyc + 1});
      q1.push_back('{mq[0], cyc + 2});
    end
    @(posedge clk);
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    if (f) begin
      mq.delete();
      q0.delete();
      q1.delete();
    end
    #1;
    we = 1'b0; re = 1'b0; flush = 1'b0;
    chk_state();
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].c < cyc) begin
      chk("l1_lost", 32'(cyc), 32'(q0[0].c));
      void'(q0.pop_front());
    end
    if (rvalid0 && q0.size() > 0) begin
      chk("l1_rdata", 32'(rdata0), 32'(q0[0].d));
      chk("l1_latency", 32'(cyc), 32'(q0[0].c));
      void'(q0.pop_front());
    end else chk("l1_rvalid", 32'(rvalid0), 32'(0));
  end

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].c < cyc) begin
      chk("l2_lost", 32'(cyc), 32'(q1[0].c));
      void'(q1.pop_front());
    end
    if (rvalid1 && q1.size() > 0) begin
      chk("l2_rdata", 32'(rdata1), 32'(q1[0].d));
      chk("l2_latency", 32'(cyc), 32'(q1[0].c));
      void'(q1.pop_front());
    end else chk("l2_rvalid", 32'(rvalid1), 32'(0));
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 16; i++) cyc_op(1'b1, 1'b0, 8'(i), 1'b0);
    cyc_op(1'b1, 1'b0, 8'hee, 1'b0);
    cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cyc_op(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc_op(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 8; i++) cyc_op(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    cyc_op(1'b1, 1'b1, 8'hee, 1'b0);
    for (int i = 0; i < 15; i++) cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    cyc_op(1'b1, 1'b1, 8'h77, 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc_op(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    cyc_op(1'b1, 1'b1, 8'hee, 1'b1);
    chk("l1_flush_rvalid", 32'(rvalid0), 32'(0));
    chk("l2_flush_rvalid", 32'(rvalid1), 32'(0));
    repeat (3) cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cyc_op(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    mq.delete();
    q0.delete();
    q1.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_op(1'b1, 1'b0, 8'ha0, 1'b0);
    cyc_op(1'b1, 1'b0, 8'ha1, 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    cyc_op(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) cyc_op(1'b0, 1'b0, 8'h00, 1'b0);
    chk("l1_drained", 32'(q0.size()), 32'(0));
    chk("l2_drained", 32'(q1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
